// File: rtl/xdn_pkg.sv
// Shared constants for the XDN 8-bit CPU control path: opcodes, micro-step
// encodings and control-word bit positions.
package xdn_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int ADDRESS_WIDTH = 4;
    localparam int OPCODE_WIDTH  = DATA_WIDTH / 2;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // Control word bits are active-high; the top converts to port polarity.
    localparam int CW_PC_CE    = 0;
    localparam int CW_PC_JUMP  = 1;
    localparam int CW_PC_OUT   = 2;
    localparam int CW_A_IN     = 3;
    localparam int CW_A_OUT    = 4;
    localparam int CW_B_IN     = 5;
    localparam int CW_B_OUT    = 6;
    localparam int CW_IR_IN    = 7;
    localparam int CW_IR_OUT   = 8;
    localparam int CW_ALU_OUT  = 9;
    localparam int CW_ALU_SUB  = 10;
    localparam int CW_FLAGS_UP = 11;
    localparam int CW_MAR_IN   = 12;
    localparam int CW_RAM_IN   = 13;
    localparam int CW_RAM_OUT  = 14;
    localparam int CW_OUT_IN   = 15;
    localparam int CW_WIDTH    = 16;

    typedef logic [CW_WIDTH-1:0] ctrl_word_t;

endpackage

// File: rtl/microcode_decoder.sv
// Combinational microcode ROM: (opcode, step, flags) -> control word,
// last-step marker and halt request.
module microcode_decoder
    import xdn_pkg::*;
#(
    parameter int OPCODE_WIDTH = xdn_pkg::OPCODE_WIDTH
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  step_t                   step,
    input  logic                    zero_flag,
    input  logic                    carry_flag,
    output ctrl_word_t              ctrl,
    output logic                    last_step,
    output logic                    halt_req
);

    always_comb begin
        ctrl      = '0;
        last_step = 1'b0;
        halt_req  = 1'b0;
        case (step)
            T0: begin
                ctrl[CW_PC_OUT] = 1'b1;
                ctrl[CW_MAR_IN] = 1'b1;
            end
            T1: begin
                ctrl[CW_RAM_OUT] = 1'b1;
                ctrl[CW_IR_IN]   = 1'b1;
                ctrl[CW_PC_CE]   = 1'b1;
            end
            T2: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl[CW_IR_OUT] = 1'b1;
                        ctrl[CW_MAR_IN] = 1'b1;
                        last_step       = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl[CW_IR_OUT] = 1'b1;
                        ctrl[CW_A_IN]   = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl[CW_IR_OUT]  = 1'b1;
                        ctrl[CW_PC_JUMP] = 1'b1;
                    end
                    OP_JC: begin
                        ctrl[CW_IR_OUT]  = carry_flag;
                        ctrl[CW_PC_JUMP] = carry_flag;
                    end
                    OP_JZ: begin
                        ctrl[CW_IR_OUT]  = zero_flag;
                        ctrl[CW_PC_JUMP] = zero_flag;
                    end
                    OP_OUT: begin
                        ctrl[CW_A_OUT]  = 1'b1;
                        ctrl[CW_OUT_IN] = 1'b1;
                    end
                    OP_HLT: halt_req = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA: begin
                        ctrl[CW_RAM_OUT] = 1'b1;
                        ctrl[CW_A_IN]    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl[CW_RAM_OUT] = 1'b1;
                        ctrl[CW_B_IN]    = 1'b1;
                        last_step        = 1'b0;
                    end
                    OP_STA: begin
                        ctrl[CW_A_OUT]  = 1'b1;
                        ctrl[CW_RAM_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    ctrl[CW_ALU_OUT]  = 1'b1;
                    ctrl[CW_A_IN]     = 1'b1;
                    ctrl[CW_FLAGS_UP] = 1'b1;
                    ctrl[CW_ALU_SUB]  = (opcode == OP_SUB);
                end
            end
            // Unused encodings fall back to T0 on the next edge.
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// XDN CPU micro-step sequencer: step counter, halted flag, clear override
// and unpacking of the microcode word onto the datapath strobes.
//
// state | meaning
// T0    | fetch: PC -> MAR
// T1    | fetch: RAM -> IR, PC increments
// T2-T4 | execute micro-steps, length depends on opcode
// (halted flag) | counter frozen at T2, all strobes idle until clear
module control_sequencer
    import xdn_pkg::*;
#(
    parameter int DATA_WIDTH = xdn_pkg::DATA_WIDTH
) (
    input  logic                    i_CLOCK,
    input  logic                    i_CLEAR,
    input  logic [DATA_WIDTH/2-1:0] i_IR_DATA,
    input  logic                    i_ZERO_FLAG,
    input  logic                    i_CARRY_FLAG,
    output logic                    o_PC_COUNT_ENABLE,
    output logic                    o_PC_JUMP_n,
    output logic                    o_PC_WRITE_BUS_n,
    output logic                    o_A_READ_BUS_n,
    output logic                    o_A_WRITE_BUS_n,
    output logic                    o_B_READ_BUS_n,
    output logic                    o_B_WRITE_BUS_n,
    output logic                    o_IR_READ_BUS_n,
    output logic                    o_IR_WRITE_BUS_n,
    output logic                    o_ALU_WRITE_BUS_n,
    output logic                    o_ALU_SUBTRACT,
    output logic                    o_FLAGS_UPDATE_n,
    output logic                    o_MAR_READ_BUS_n,
    output logic                    o_RAM_READ_BUS,
    output logic                    o_RAM_WRITE_BUS_n,
    output logic                    o_OUT_READ_BUS,
    output logic                    o_HALT,
    output logic [2:0]              o_STEP
);

    step_t      step, step_next;
    logic       halted, halted_next;
    ctrl_word_t ctrl, ctrl_act;
    logic       last_step, halt_req;

    microcode_decoder #(.OPCODE_WIDTH(DATA_WIDTH/2)) u_decoder (
        .opcode     (i_IR_DATA),
        .step       (step),
        .zero_flag  (i_ZERO_FLAG),
        .carry_flag (i_CARRY_FLAG),
        .ctrl       (ctrl),
        .last_step  (last_step),
        .halt_req   (halt_req)
    );

    always_ff @(posedge i_CLOCK) begin
        if (i_CLEAR) begin
            step   <= T0;
            halted <= 1'b0;
        end else begin
            step   <= step_next;
            halted <= halted_next;
        end
    end

    // HLT keeps the counter parked at T2 so the LEDs show where it stopped.
    always_comb begin
        step_next   = step;
        halted_next = halted;
        if (!halted) begin
            if (halt_req)
                halted_next = 1'b1;
            else if (last_step)
                step_next = T0;
            else
                step_next = step_t'(step + 3'd1);
        end
    end

    assign ctrl_act = (i_CLEAR || halted) ? '0 : ctrl;

    assign o_PC_COUNT_ENABLE = ctrl_act[CW_PC_CE];
    assign o_PC_JUMP_n       = ~ctrl_act[CW_PC_JUMP];
    assign o_PC_WRITE_BUS_n  = ~ctrl_act[CW_PC_OUT];
    assign o_A_READ_BUS_n    = ~ctrl_act[CW_A_IN];
    assign o_A_WRITE_BUS_n   = ~ctrl_act[CW_A_OUT];
    assign o_B_READ_BUS_n    = ~ctrl_act[CW_B_IN];
    assign o_B_WRITE_BUS_n   = ~ctrl_act[CW_B_OUT];
    assign o_IR_READ_BUS_n   = ~ctrl_act[CW_IR_IN];
    assign o_IR_WRITE_BUS_n  = ~ctrl_act[CW_IR_OUT];
    assign o_ALU_WRITE_BUS_n = ~ctrl_act[CW_ALU_OUT];
    assign o_ALU_SUBTRACT    = ctrl_act[CW_ALU_SUB];
    assign o_FLAGS_UPDATE_n  = ~ctrl_act[CW_FLAGS_UP];
    assign o_MAR_READ_BUS_n  = ~ctrl_act[CW_MAR_IN];
    assign o_RAM_READ_BUS    = ctrl_act[CW_RAM_IN];
    assign o_RAM_WRITE_BUS_n = ~ctrl_act[CW_RAM_OUT];
    assign o_OUT_READ_BUS    = ctrl_act[CW_OUT_IN];
    assign o_HALT            = halted & ~i_CLEAR;
    assign o_STEP            = i_CLEAR ? 3'd0 : step;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction runs plus a
// randomized opcode/flag/clear stream against a transfer-level reference model.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       i_CLEAR = 1'b1;
    logic [3:0] i_IR_DATA = 4'h0;
    logic       i_ZERO_FLAG = 1'b0;
    logic       i_CARRY_FLAG = 1'b0;
    logic pc_ce, pc_jump_n, pc_wb_n, a_rb_n, a_wb_n, b_rb_n, b_wb_n;
    logic ir_rb_n, ir_wb_n, alu_wb_n, alu_sub, flags_n, mar_rb_n;
    logic ram_rb, ram_wb_n, out_rb, halt;
    logic [2:0] step;

    always #5 clk = ~clk;

    control_sequencer #(.DATA_WIDTH(8)) dut (
        .i_CLOCK           (clk),
        .i_CLEAR           (i_CLEAR),
        .i_IR_DATA         (i_IR_DATA),
        .i_ZERO_FLAG       (i_ZERO_FLAG),
        .i_CARRY_FLAG      (i_CARRY_FLAG),
        .o_PC_COUNT_ENABLE (pc_ce),
        .o_PC_JUMP_n       (pc_jump_n),
        .o_PC_WRITE_BUS_n  (pc_wb_n),
        .o_A_READ_BUS_n    (a_rb_n),
        .o_A_WRITE_BUS_n   (a_wb_n),
        .o_B_READ_BUS_n    (b_rb_n),
        .o_B_WRITE_BUS_n   (b_wb_n),
        .o_IR_READ_BUS_n   (ir_rb_n),
        .o_IR_WRITE_BUS_n  (ir_wb_n),
        .o_ALU_WRITE_BUS_n (alu_wb_n),
        .o_ALU_SUBTRACT    (alu_sub),
        .o_FLAGS_UPDATE_n  (flags_n),
        .o_MAR_READ_BUS_n  (mar_rb_n),
        .o_RAM_READ_BUS    (ram_rb),
        .o_RAM_WRITE_BUS_n (ram_wb_n),
        .o_OUT_READ_BUS    (out_rb),
        .o_HALT            (halt),
        .o_STEP            (step)
    );

    logic [19:0] dut_vec;
    assign dut_vec = {pc_ce, pc_jump_n, pc_wb_n, a_rb_n, a_wb_n, b_rb_n, b_wb_n,
                      ir_rb_n, ir_wb_n, alu_wb_n, alu_sub, flags_n, mar_rb_n,
                      ram_rb, ram_wb_n, out_rb, halt, step};

    localparam int S_NONE = 0, S_PC = 1, S_RAM = 2, S_IR = 3, S_A = 4, S_ALU = 5;
    localparam int D_NONE = 0, D_MAR = 1, D_IR = 2, D_A = 3, D_B = 4, D_OUT = 5,
                   D_RAM = 6, D_PC = 7;

    int n_vec = 0;
    int n_fail = 0;
    int m_step = 0;
    logic m_halted = 1'b0;
    logic [3:0] instr_op = 4'h0;
    int cyc = 0;
    logic len_valid = 1'b0;
    logic [3:0] len_op = 4'h0;
    int ram_rb_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int instr_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    // Each micro-step is one bus transfer (source -> destination) plus side strobes.
    function automatic logic [19:0] model_out(input logic clr, input logic hlt, input int t,
                                              input logic [3:0] op, input logic z, input logic c);
        int src, dst;
        logic ce, flg, sub;
        src = S_NONE; dst = D_NONE; ce = 1'b0; flg = 1'b0; sub = 1'b0;
        if (!clr && !hlt) begin
            if (t == 0) begin src = S_PC; dst = D_MAR; end
            else if (t == 1) begin src = S_RAM; dst = D_IR; ce = 1'b1; end
            else begin
                case (op)
                    4'h1: if (t == 2) begin src = S_IR; dst = D_MAR; end
                          else if (t == 3) begin src = S_RAM; dst = D_A; end
                    4'h2, 4'h3: if (t == 2) begin src = S_IR; dst = D_MAR; end
                          else if (t == 3) begin src = S_RAM; dst = D_B; end
                          else if (t == 4) begin src = S_ALU; dst = D_A; flg = 1'b1; sub = (op == 4'h3); end
                    4'h4: if (t == 2) begin src = S_IR; dst = D_MAR; end
                          else if (t == 3) begin src = S_A; dst = D_RAM; end
                    4'h5: if (t == 2) begin src = S_IR; dst = D_A; end
                    4'h6: if (t == 2) begin src = S_IR; dst = D_PC; end
                    4'h7: if (t == 2 && c) begin src = S_IR; dst = D_PC; end
                    4'h8: if (t == 2 && z) begin src = S_IR; dst = D_PC; end
                    4'hE: if (t == 2) begin src = S_A; dst = D_OUT; end
                    default: ;
                endcase
            end
        end
        return {ce, !(dst == D_PC), !(src == S_PC), !(dst == D_A), !(src == S_A),
                !(dst == D_B), 1'b1, !(dst == D_IR), !(src == S_IR), !(src == S_ALU),
                sub, !flg, !(dst == D_MAR), (dst == D_RAM), !(src == S_RAM),
                (dst == D_OUT), (hlt && !clr), (clr ? 3'd0 : 3'(t))};
    endfunction

    task automatic run_cycle(input logic clr, input logic z, input logic c);
        int wl;
        @(negedge clk);
        i_CLEAR      = clr;
        i_ZERO_FLAG  = z;
        i_CARRY_FLAG = c;
        i_IR_DATA    = (m_step >= 2) ? instr_op : 4'($urandom);
        #1;
        check_val("ctl_word", 32'(dut_vec), 32'(model_out(clr, m_halted, m_step, instr_op, z, c)));
        wl = int'(!pc_wb_n) + int'(!a_wb_n) + int'(!b_wb_n) + int'(!ir_wb_n)
           + int'(!alu_wb_n) + int'(!ram_wb_n);
        check_val("bus_excl", 32'(wl <= 1), 32'd1);
        if (ram_rb) ram_rb_seen++;
        if (clr || m_halted || halt) len_valid = 1'b0;
        else if (step == 3'd0) begin
            if (len_valid) check_val("instr_len", 32'(cyc), 32'(instr_len(len_op)));
            len_valid = 1'b1;
            len_op    = instr_op;
            cyc       = 1;
        end else cyc++;
        if (clr) begin
            m_step = 0; m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_step == 2 && instr_op == 4'hF) m_halted = 1'b1;
            else if (m_step + 1 == instr_len(instr_op)) m_step = 0;
            else m_step++;
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input logic c);
        instr_op = op;
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b0, z, c);
            if (m_step == 0 || m_halted) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic clr;
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0);
        instr_op = 4'h0;
        run_cycle(1'b0, 1'b0, 1'b0);
        check_val("reset_t0_pc", 32'(pc_wb_n), 32'd0);
        check_val("reset_t0_mar", 32'(mar_rb_n), 32'd0);
        run_cycle(1'b0, 1'b0, 1'b0);
        check_val("reset_t1_ce", 32'(pc_ce), 32'd1);
        run_cycle(1'b0, 1'b0, 1'b0);

        run_instr(4'h2, 1'b0, 1'b0);
        run_instr(4'h3, 1'b1, 1'b1);
        run_instr(4'h7, 1'b1, 1'b0);
        run_instr(4'h7, 1'b0, 1'b1);
        run_instr(4'h8, 1'b0, 1'b1);
        run_instr(4'h8, 1'b1, 1'b0);
        run_instr(4'h1, 1'b0, 1'b0);
        run_instr(4'h4, 1'b0, 1'b0);
        run_instr(4'h5, 1'b0, 1'b0);
        run_instr(4'h6, 1'b0, 1'b0);
        run_instr(4'hE, 1'b0, 1'b0);
        run_instr(4'hA, 1'b1, 1'b1);
        run_instr(4'h0, 1'b0, 1'b0);

        run_instr(4'hF, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            run_cycle(1'b0, 1'($urandom), 1'($urandom));
            check_val("halt_flag", 32'(halt), 32'd1);
            check_val("halt_step", 32'(step), 32'd2);
        end
        run_cycle(1'b1, 1'b0, 1'b0);
        instr_op = 4'h0;
        run_cycle(1'b0, 1'b0, 1'b0);
        check_val("unhalt_step", 32'(step), 32'd0);
        check_val("unhalt_flag", 32'(halt), 32'd0);
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);

        instr_op = 4'h4;
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        ram_rb_seen = 0;
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        check_val("abort_next_t0", 32'(step), 32'd0);
        run_instr(4'h4, 1'b0, 1'b0);
        check_val("abort_no_store", 32'(ram_rb_seen), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            clr = 1'b0;
            if (m_step == 0 && !m_halted) instr_op = 4'($urandom);
            if (m_halted && $urandom_range(0, 3) == 0) clr = 1'b1;
            else if ($urandom_range(0, 63) == 0) clr = 1'b1;
            run_cycle(clr, 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcoded control unit for the XDN 8-bit CPU. Replaces the top level's fixed three-state loop. It steps through fetch and execute micro-steps, decodes the instruction register opcode and the ALU flags, and drives every bus-enable and load strobe of the PC, A, B, IR, ALU, MAR, RAM and Output modules. It sits between the instruction register/ALU flags and the datapath control inputs, and is clocked by the Clock module's gated `CLOCK`.

## Interface
- `DATA_WIDTH`, 8: bus width. The opcode width is `DATA_WIDTH/2`.
- `ADDRESS_WIDTH`, 4: MAR/RAM address width. Used only for the package constants.
- `i_CLOCK` in 1: CPU clock, rising-edge active.
- `i_CLEAR` in 1: reset, synchronous, active-high.
- `i_IR_DATA` in `DATA_WIDTH/2`: opcode nibble from the instruction register.
- `i_ZERO_FLAG`, `i_CARRY_FLAG` in 1 each: registered ALU flags.
- `o_PC_COUNT_ENABLE`, `o_PC_JUMP_n`, `o_PC_WRITE_BUS_n` out 1 each.
- `o_A_READ_BUS_n`, `o_A_WRITE_BUS_n`, `o_B_READ_BUS_n`, `o_B_WRITE_BUS_n` out 1 each.
- `o_IR_READ_BUS_n`, `o_IR_WRITE_BUS_n` out 1 each. `o_IR_WRITE_BUS_n` drives the operand nibble onto the bus.
- `o_ALU_WRITE_BUS_n`, `o_ALU_SUBTRACT`, `o_FLAGS_UPDATE_n` out 1 each.
- `o_MAR_READ_BUS_n` out 1.
- `o_RAM_READ_BUS` out 1: RAM stores the bus value.
- `o_RAM_WRITE_BUS_n` out 1: RAM drives the bus.
- `o_OUT_READ_BUS` out 1.
- `o_HALT` out 1: tie to the Clock module's `CLOCK_HALT`.
- `o_STEP` out 3: current micro-step, for the LEDs.

## Operation
- A step counter runs T0–T4. A HALTED state is held as a separate flag.
- Fetch is common to all opcodes:
  - T0: `PC_WRITE_BUS_n`=0, `MAR_READ_BUS_n`=0.
  - T1: `RAM_WRITE_BUS_n`=0, `IR_READ_BUS_n`=0, `PC_COUNT_ENABLE`=1.
- Execute steps by opcode (T2 onward):
  - 0x0 NOP: T2 idle.
  - 0x1 LDA: T2 IR→MAR; T3 RAM→A.
  - 0x2 ADD: T2 IR→MAR; T3 RAM→B; T4 ALU→A with `FLAGS_UPDATE_n`=0 and `ALU_SUBTRACT`=0.
  - 0x3 SUB: same as ADD, but `ALU_SUBTRACT`=1 in T4 only.
  - 0x4 STA: T2 IR→MAR; T3 `A_WRITE_BUS_n`=0 and `RAM_READ_BUS`=1.
  - 0x5 LDI: T2 IR→A.
  - 0x6 JMP: T2 `IR_WRITE_BUS_n`=0 and `PC_JUMP_n`=0.
  - 0x7 JC: performs the JMP step only if `i_CARRY_FLAG`=1 during T2; otherwise T2 is idle.
  - 0x8 JZ: performs the JMP step only if `i_ZERO_FLAG`=1 during T2; otherwise T2 is idle.
  - 0xE OUT: T2 `A_WRITE_BUS_n`=0 and `OUT_READ_BUS`=1.
  - 0xF HLT: T2 sets the halted flag.
  - 0x9–0xD: treated as NOP.
- Variable length: on the rising edge that ends an opcode's last step, the counter returns to T0. The cycle counts are:
  - NOP, LDI, JMP, JC, JZ, OUT, HLT: 3 cycles.
  - LDA, STA: 4 cycles.
  - ADD, SUB: 5 cycles.
- Halted:
  - `o_HALT`=1 and the step counter freezes at T2.
  - All control outputs are inactive.
  - Only `i_CLEAR` exits the halted state.
- Bus invariant: at most one of `PC/A/B/IR/ALU/RAM *_WRITE_BUS_n` is low in any cycle.
- Inactive levels: every `_n` output is 1; every active-high output (`PC_COUNT_ENABLE`, `ALU_SUBTRACT`, `RAM_READ_BUS`, `OUT_READ_BUS`, `HALT`) is 0.

## Timing
- The step counter and halted flag are registered. All control outputs are combinational decodes of (step, opcode, flags, halted).
- Control outputs are stable for a full cycle and are sampled by the datapath on the next rising edge.
- Reset: when `i_CLEAR`=1 at a rising edge, the step counter goes to T0 and the halted flag clears.
  - Reset mid-instruction aborts the instruction; no partial step is retried.
  - While `i_CLEAR`=1, all outputs are forced inactive, `o_STEP`=0 and `o_HALT`=0.
- After reset is released, the first cycle is T0 fetch.
- `i_IR_DATA` is valid from T2 onward, because the IR loads at the end of T1. The opcode is ignored during T0 and T1.
- Flags are sampled combinationally in T2 of JC/JZ. A preceding ADD/SUB updated the flags at the end of its T4, so they are already valid.

## Structure
- Shared package `xdn_pkg` holds:
  - opcode localparams (`OP_NOP` … `OP_HLT`);
  - step encodings `T0`–`T4`;
  - the control-word bit indices.
- Sub-module `microcode_decoder`: purely combinational. It maps (opcode, step, flags) to a control word plus a "last step" bit.
- `control_sequencer` owns the counter, the halted flag, the reset override and the unpacking of the control word onto the output ports.

## Test plan
- Reset, then release: first cycle `o_STEP`=0, `PC_WRITE_BUS_n`=0, `MAR_READ_BUS_n`=0. Next cycle `RAM_WRITE_BUS_n`=0, `IR_READ_BUS_n`=0, `PC_COUNT_ENABLE`=1.
- Opcode 0x2 (ADD) held from T2: T3 `B_READ_BUS_n`=0; T4 `ALU_WRITE_BUS_n`=0, `A_READ_BUS_n`=0, `FLAGS_UPDATE_n`=0, `ALU_SUBTRACT`=0; the following cycle is T0. Repeat with 0x3 and check `ALU_SUBTRACT`=1 in T4 only.
- Opcode 0x7 with carry=0: T2 has all outputs inactive and returns to T0. With carry=1: T2 has `PC_JUMP_n`=0 and `IR_WRITE_BUS_n`=0. Repeat for 0x8 with the zero flag.
- Opcode 0xF: from the cycle after T2, `o_HALT`=1 and `o_STEP`=2 for 20 cycles with every output inactive. Asserting `i_CLEAR` returns to T0 with `o_HALT`=0.
- Assert `i_CLEAR` during T3 of STA (0x4): no `RAM_READ_BUS` pulse occurs afterwards, and the next step is T0.
- Random opcode stream over 1000 cycles: a bus-invariant checker fires on any cycle with more than one `*_WRITE_BUS_n` low. Cycle counts per opcode match 3/4/5.
